// File: rtl/microwave_countdown.sv
// BCD MM:SS cook-time countdown driven by the 1 Hz divider tick; controls the magnetron and signals end of cook.
// Optional DONE_BEEP_EN: when defined, `done` is held for BEEP_TICKS ticks after reaching 00:00 instead of pulsing for one cycle.
module microwave_countdown #(
    parameter int MAX_MIN_TENS = 9,
    parameter int BEEP_TICKS   = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       Hz1,
    input  logic       load,
    input  logic [3:0] ld_min_t,
    input  logic [3:0] ld_min_o,
    input  logic [3:0] ld_sec_t,
    input  logic [3:0] ld_sec_o,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       magnetron_on,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READY   = 2'd1,
        S_RUNNING = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] MIN_T_LIM = 4'(MAX_MIN_TENS);

    // Out-of-range parameters would let digits escape the BCD range.
    if (MAX_MIN_TENS > 9 || MAX_MIN_TENS < 0 || BEEP_TICKS < 1) begin : g_param_check
        $error("microwave_countdown: MAX_MIN_TENS must be 0..9 and BEEP_TICKS >= 1");
    end

    function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] min_t_q, min_t_d;
    logic [3:0] min_o_q, min_o_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] sec_o_q, sec_o_d;
    logic       magnetron_on_q, magnetron_on_d;
    logic       done_q, done_d;

    logic [3:0] dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
    logic       borrow_sec_o, borrow_sec_t, borrow_min_o;
    logic       dec_is_zero;

    logic [3:0] sat_min_t, sat_min_o, sat_sec_t, sat_sec_o;
    logic       sat_is_zero;

    logic       enter_done;
    logic       load_accept;

    // Digit-wise BCD decrement with a ripple borrow from seconds-ones upward.
    always_comb begin
        borrow_sec_o = (sec_o_q == 4'd0);
        dec_sec_o    = borrow_sec_o ? 4'd9 : sec_o_q - 4'd1;

        borrow_sec_t = borrow_sec_o && (sec_t_q == 4'd0);
        dec_sec_t    = sec_t_q;
        if (borrow_sec_o) begin
            dec_sec_t = (sec_t_q == 4'd0) ? 4'd5 : sec_t_q - 4'd1;
        end

        borrow_min_o = borrow_sec_t && (min_o_q == 4'd0);
        dec_min_o    = min_o_q;
        if (borrow_sec_t) begin
            dec_min_o = (min_o_q == 4'd0) ? 4'd9 : min_o_q - 4'd1;
        end

        dec_min_t = min_t_q;
        if (borrow_min_o && (min_t_q != 4'd0)) begin
            dec_min_t = min_t_q - 4'd1;
        end

        dec_is_zero = (dec_min_t == 4'd0) && (dec_min_o == 4'd0) &&
                      (dec_sec_t == 4'd0) && (dec_sec_o == 4'd0);
    end

    always_comb begin
        sat_min_t   = sat_digit(ld_min_t, MIN_T_LIM);
        sat_min_o   = sat_digit(ld_min_o, 4'd9);
        sat_sec_t   = sat_digit(ld_sec_t, 4'd5);
        sat_sec_o   = sat_digit(ld_sec_o, 4'd9);
        sat_is_zero = (sat_min_t == 4'd0) && (sat_min_o == 4'd0) &&
                      (sat_sec_t == 4'd0) && (sat_sec_o == 4'd0);
    end

    // One action per cycle, highest priority first: clear, stop, door open, start, load, tick.
    always_comb begin
        state_d     = state_q;
        min_t_d     = min_t_q;
        min_o_d     = min_o_q;
        sec_t_d     = sec_t_q;
        sec_o_d     = sec_o_q;
        enter_done  = 1'b0;
        load_accept = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            min_t_d = 4'd0;
            min_o_d = 4'd0;
            sec_t_d = 4'd0;
            sec_o_d = 4'd0;
        end else if (stop) begin
            if (state_q == S_RUNNING) begin
                state_d = S_READY;
            end
        end else if (!door_closed && (state_q == S_RUNNING)) begin
            state_d = S_READY;
        end else if (start && door_closed && (state_q == S_READY)) begin
            state_d = S_RUNNING;
        end else if (load && (state_q != S_RUNNING)) begin
            load_accept = 1'b1;
            min_t_d     = sat_min_t;
            min_o_d     = sat_min_o;
            sec_t_d     = sat_sec_t;
            sec_o_d     = sat_sec_o;
            state_d     = sat_is_zero ? S_IDLE : S_READY;
        end else if (Hz1 && (state_q == S_RUNNING)) begin
            min_t_d = dec_min_t;
            min_o_d = dec_min_o;
            sec_t_d = dec_sec_t;
            sec_o_d = dec_sec_o;
            if (dec_is_zero) begin
                state_d    = S_DONE;
                enter_done = 1'b1;
            end
        end

        magnetron_on_d = (state_d == S_RUNNING);
    end

`ifdef DONE_BEEP_EN
    localparam int BEEP_W = (BEEP_TICKS < 2) ? 1 : $clog2(BEEP_TICKS + 1);

    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    // done holds through BEEP_TICKS ticks after entry; the tick that enters DONE does not count.
    always_comb begin
        done_d     = done_q;
        beep_cnt_d = beep_cnt_q;
        if (clear || load_accept) begin
            done_d     = 1'b0;
            beep_cnt_d = '0;
        end else if (enter_done) begin
            done_d     = 1'b1;
            beep_cnt_d = BEEP_W'(BEEP_TICKS);
        end else if (Hz1 && done_q) begin
            if (beep_cnt_q <= BEEP_W'(1)) begin
                done_d     = 1'b0;
                beep_cnt_d = '0;
            end else begin
                beep_cnt_d = beep_cnt_q - BEEP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end
`else
    always_comb begin
        done_d = enter_done;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            min_t_q        <= 4'd0;
            min_o_q        <= 4'd0;
            sec_t_q        <= 4'd0;
            sec_o_q        <= 4'd0;
            magnetron_on_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            min_t_q        <= min_t_d;
            min_o_q        <= min_o_d;
            sec_t_q        <= sec_t_d;
            sec_o_q        <= sec_o_d;
            magnetron_on_q <= magnetron_on_d;
            done_q         <= done_d;
        end
    end

    assign min_t        = min_t_q;
    assign min_o        = min_o_q;
    assign sec_t        = sec_t_q;
    assign sec_o        = sec_o_q;
    assign magnetron_on = magnetron_on_q;
    assign done         = done_q;

endmodule

// File: tb/tb_microwave_countdown.sv
// Directed bench for microwave_countdown (base build): each step queues its expected outputs, clocks once, then checks.
module tb_microwave_countdown;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       Hz1, load, start, stop, clear, door_closed;
    logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       magnetron_on, done;

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    microwave_countdown #(.MAX_MIN_TENS(9), .BEEP_TICKS(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .Hz1         (Hz1),
        .load        (load),
        .ld_min_t    (ld_min_t),
        .ld_min_o    (ld_min_o),
        .ld_sec_t    (ld_sec_t),
        .ld_sec_o    (ld_sec_o),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .min_t       (min_t),
        .min_o       (min_o),
        .sec_t       (sec_t),
        .sec_o       (sec_o),
        .magnetron_on(magnetron_on),
        .done        (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] E(input logic [3:0] mt, input logic [3:0] mo,
                                      input logic [3:0] st, input logic [3:0] so,
                                      input logic mag, input logic dn);
        return {mt, mo, st, so, mag, dn};
    endfunction

    task automatic compare();
        sb_t         e;
        logic [17:0] obs;
        obs = {min_t, min_o, sec_t, sec_o, magnetron_on, done};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h required=expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [17:0] exp);
        sb_q.push_back('{tag, exp});
        compare();
    endtask

    task automatic step(input string tag, input logic [17:0] exp);
        sb_q.push_back('{tag, exp});
        @(posedge clock);
        #1;
        Hz1 = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        compare();
    endtask

    task automatic set_ld(input logic [3:0] mt, input logic [3:0] mo,
                          input logic [3:0] st, input logic [3:0] so);
        ld_min_t = mt; ld_min_o = mo; ld_sec_t = st; ld_sec_o = so;
        load = 1'b1;
    endtask

    task automatic tick_unchecked();
        Hz1 = 1'b1;
        @(posedge clock);
        #1;
        Hz1 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        Hz1 = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        door_closed = 1'b1;
        ld_min_t = 4'd0; ld_min_o = 4'd0; ld_sec_t = 4'd0; ld_sec_o = 4'd0;
        #12;
        check_now("reset_state", E(0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Start/zero rules.
        start = 1'b1;               step("idle_start_ignored", E(0, 0, 0, 0, 0, 0));
        set_ld(0, 0, 0, 0);         step("load_zero_idle",     E(0, 0, 0, 0, 0, 0));
        start = 1'b1;               step("start_after_zero",   E(0, 0, 0, 0, 0, 0));

        // Basic countdown 00:03.
        set_ld(0, 0, 0, 3);         step("load_0003",    E(0, 0, 0, 3, 0, 0));
        start = 1'b1;               step("start_0003",   E(0, 0, 0, 3, 1, 0));
        Hz1 = 1'b1;                 step("tick_0002",    E(0, 0, 0, 2, 1, 0));
        Hz1 = 1'b1;                 step("tick_0001",    E(0, 0, 0, 1, 1, 0));
        Hz1 = 1'b1;                 step("tick_0000",    E(0, 0, 0, 0, 0, 1));
                                    step("done_one_cyc", E(0, 0, 0, 0, 0, 0));
        Hz1 = 1'b1;                 step("tick_in_done", E(0, 0, 0, 0, 0, 0));
        start = 1'b1;               step("start_in_done",E(0, 0, 0, 0, 0, 0));

        // Borrow chain from 10:00.
        set_ld(1, 0, 0, 0);         step("load_1000",    E(1, 0, 0, 0, 0, 0));
        start = 1'b1;               step("start_1000",   E(1, 0, 0, 0, 1, 0));
        Hz1 = 1'b1;                 step("borrow_0959",  E(0, 9, 5, 9, 1, 0));
        for (int i = 0; i < 59; i++) tick_unchecked();
        Hz1 = 1'b1;                 step("sixty_0859",   E(0, 8, 5, 9, 1, 0));
        set_ld(0, 0, 0, 7);         step("load_running_ignored", E(0, 8, 5, 9, 1, 0));
        clear = 1'b1;               step("clear_running",E(0, 0, 0, 0, 0, 0));

        // Saturation.
        set_ld(12, 15, 7, 10);      step("sat_load",     E(9, 9, 5, 9, 0, 0));
        start = 1'b1;               step("sat_is_ready", E(9, 9, 5, 9, 1, 0));
        Hz1 = 1'b1;                 step("tick_9958",    E(9, 9, 5, 8, 1, 0));
        clear = 1'b1;               step("clear_sat",    E(0, 0, 0, 0, 0, 0));

        // Door handling and priority.
        set_ld(0, 0, 3, 0);         step("load_0030",    E(0, 0, 3, 0, 0, 0));
        start = 1'b1;               step("start_0030",   E(0, 0, 3, 0, 1, 0));
        Hz1 = 1'b1; door_closed = 1'b0;
                                    step("door_open_tick", E(0, 0, 3, 0, 0, 0));
        start = 1'b1;               step("start_door_open",E(0, 0, 3, 0, 0, 0));
        door_closed = 1'b1;         step("door_close",     E(0, 0, 3, 0, 0, 0));
        start = 1'b1;               step("resume",         E(0, 0, 3, 0, 1, 0));
        Hz1 = 1'b1;                 step("tick_0029",      E(0, 0, 2, 9, 1, 0));
        stop = 1'b1; Hz1 = 1'b1;    step("stop_with_tick", E(0, 0, 2, 9, 0, 0));
        stop = 1'b1; start = 1'b1;  step("stop_beats_start", E(0, 0, 2, 9, 0, 0));

        // Start and tick together from READY 00:05.
        clear = 1'b1;               step("clear_paused", E(0, 0, 0, 0, 0, 0));
        set_ld(0, 0, 0, 5);         step("load_0005",    E(0, 0, 0, 5, 0, 0));
        start = 1'b1; Hz1 = 1'b1;   step("start_and_tick", E(0, 0, 0, 5, 1, 0));
        Hz1 = 1'b1;                 step("tick_0004",    E(0, 0, 0, 4, 1, 0));

        // Asynchronous reset mid-run, checked before the next clock edge.
        #1;
        reset_n = 1'b0;
        #1;
        check_now("async_reset", E(0, 0, 0, 0, 0, 0));
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b1;               step("post_reset_idle", E(0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
